dc_token_reader: RTL and testbench

DC_TOKEN_READER -- requirements
Module: dc_token_reader

---
 rtl/dc_token_reader.sv | 81 ++++++++
 tb/tb_dc_token_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dc_token_reader.sv
// Reader side of a toggle-token dual-clock buffer.
// Synchronizes the writer token and streams entries out through one output register.
module dc_token_reader #(
  parameter int BUFFER_WIDTH = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [BUFFER_WIDTH-1:0]            write_token_i,
  input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_i,
  output logic [BUFFER_WIDTH-1:0]            read_pointer_o,
  output logic                               valid_o,
  output logic [DATA_WIDTH-1:0]              data_o,
  input  logic                               ready_i,
  output logic [$clog2(BUFFER_WIDTH+1)-1:0]  level_o
);

  localparam int IW = $clog2(BUFFER_WIDTH);
  localparam int LW = $clog2(BUFFER_WIDTH+1);

  logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] tok_s;
  logic [BUFFER_WIDTH-1:0] full;
  logic [IW-1:0]           rd_idx;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    last_idx;
  logic                    load;

  // First stage samples the raw token with nothing in front of it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= write_token_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign tok_s    = sync_q[SYNC_STAGES-1];
  assign full     = tok_s ^ read_pointer_o;
  assign load     = full[rd_idx] & (~valid_o | ready_i);
  assign rd_data  = data_i[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign last_idx = (rd_idx == IW'(BUFFER_WIDTH-1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_pointer_o <= '0;
      rd_idx         <= '0;
      valid_o        <= 1'b0;
      data_o         <= '0;
    end else if (load) begin
      data_o                 <= rd_data;
      valid_o                <= 1'b1;
      read_pointer_o[rd_idx] <= ~read_pointer_o[rd_idx];
      rd_idx                 <= last_idx ? '0 : rd_idx + 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  always_comb begin
    level_o = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      level_o = level_o + LW'(full[i]);
    end
  end

  a_one_toggle: assert property (
    @(posedge clk_i) disable iff (rst_i)
    $countones(read_pointer_o ^ $past(read_pointer_o)) <= 1);

  a_hold_data: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> $stable(data_o));

endmodule

// File: tb/tb_dc_token_reader.sv
// Randomized bench for dc_token_reader.
// A writer model feeds a payload queue; outputs are scoreboarded in order.
module tb_dc_token_reader;

  localparam int BW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [BW-1:0]   tok;
  logic [BW*DW-1:0] data_i;
  logic [BW-1:0]   rp;
  logic            valid;
  logic [DW-1:0]   data_o;
  logic            ready;
  logic [3:0]      level;

  int n_checks = 0;
  int n_err    = 0;
  int wr_idx   = 0;
  logic [DW-1:0] expq [$];
  logic [BW-1:0] exp_rp;

  dc_token_reader #(
    .BUFFER_WIDTH(BW),
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .write_token_i (tok),
    .data_i        (data_i),
    .read_pointer_o(rp),
    .valid_o       (valid),
    .data_o        (data_o),
    .ready_i       (ready),
    .level_o       (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_push(input logic [DW-1:0] v);
    data_i[wr_idx*DW +: DW] = v;
    tok[wr_idx] = ~tok[wr_idx];
    expq.push_back(v);
    wr_idx = (wr_idx + 1) % BW;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready = 1'b0;
    tok = '0;
    data_i = '0;
    wr_idx = 0;
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Writer and consumer run together; every accepted word is popped in order
  task automatic run_stream(input int n, input bit rand_ready,
                            input int max_cyc);
    int left = n;
    int cyc = 0;
    while ((left > 0 || expq.size() > 0) && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (left > 0 && tok[wr_idx] == rp[wr_idx] &&
          $urandom_range(0, 3) != 0) begin
        wr_push($urandom);
        left--;
      end
      @(negedge clk);
      if (valid && ready) begin
        if (expq.size() == 0) check("extra_out", 1, 0);
        else check("stream_data", data_o, expq.pop_front());
      end
    end
    check("stream_done", 64'(expq.size() + left), 0);
    @(posedge clk);
    #1 ready = 1'b0;
    check("stream_idle", valid, 0);
    check("stream_lvl", level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ready = 1'b0;
    tok = '0;
    data_i = '0;
    @(negedge clk);
    check("rst_rp", rp, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data_o, 0);
    check("rst_level", level, 0);

    // single write latency
    do_reset();
    ready = 1'b1;
    wr_push(32'hA5A5_0001);
    @(posedge clk); #1;
    check("t1_e1_valid", valid, 0);
    @(posedge clk); #1;
    check("t1_e2_valid", valid, 0);
    check("t1_e2_level", level, 1);
    @(posedge clk); #1;
    check("t1_valid", valid, 1);
    check("t1_data", data_o, 32'hA5A5_0001);
    check("t1_rp", rp, 8'h01);
    check("t1_level", level, 0);
    @(posedge clk); #1;
    check("t1_clear", valid, 0);

    // backpressure
    do_reset();
    wr_push(32'h1111_0000);
    @(posedge clk); #1;
    wr_push(32'h2222_0001);
    @(posedge clk); #1;
    wr_push(32'h3333_0002);
    repeat (5) @(posedge clk);
    #1;
    check("t2_valid", valid, 1);
    check("t2_data0", data_o, 32'h1111_0000);
    check("t2_level", level, 2);
    check("t2_rp", rp, 8'h01);
    ready = 1'b1;
    @(posedge clk); #1;
    check("t2_data1", data_o, 32'h2222_0001);
    check("t2_v1", valid, 1);
    @(posedge clk); #1;
    check("t2_data2", data_o, 32'h3333_0002);
    check("t2_v2", valid, 1);
    @(posedge clk); #1;
    check("t2_end_valid", valid, 0);
    check("t2_end_rp", rp, 8'h07);

    // wrap-around with random ready
    do_reset();
    run_stream(20, 1'b1, 2000);
    exp_rp = '0;
    for (int k = 0; k < 20; k++) exp_rp[k % BW] = ~exp_rp[k % BW];
    check("t3_rp", rp, exp_rp);
    check("t3_rp_const", rp, 8'h0F);

    // all entries full
    do_reset();
    for (int k = 0; k < BW; k++) begin
      wr_push(32'hC0DE_0000 | k);
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check("t4_level", level, 7);
    check("t4_valid", valid, 1);
    check("t4_data0", data_o, 32'hC0DE_0000);
    run_stream(0, 1'b0, 100);
    check("t4_rp", rp, 8'hFF);

    // long random run crossing several wraps
    do_reset();
    run_stream(37, 1'b1, 4000);

    // reset mid-stream
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wr_push(32'hBEEF_0000 | k);
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check("t5_pre_valid", valid, 1);
    check("t5_pre_level", level, 3);
    #2 rst = 1'b1;
    #1;
    check("t5_rp", rp, 0);
    check("t5_valid", valid, 0);
    check("t5_data", data_o, 0);
    check("t5_level", level, 0);
    do_reset();
    wr_push(32'h1234_5678);
    run_stream(0, 1'b0, 20);
    check("t5_after_rp", rp, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
